// File: rtl/kpn_display_pkg.sv
// Shared definitions for the KPN display path: FSM state encoding and BCD
// formatting constants used by binary_to_bcd_stage and write_to_display users.
package kpn_display_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = BCD_DIGITS * DIGIT_W;
  localparam int MAX_DEC    = 9999;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/binary_to_bcd_stage_bcd_add3.sv
// bcd_add3: double-dabble digit correction. A digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/binary_to_bcd_stage.sv
// binary_to_bcd_stage: pops unsigned words from an upstream FIFO and converts
// each to four packed BCD digits, one double-dabble step per clock.
// Optional build macro BCD_SATURATE_EN: when defined, words above MAX_DEC are
// clamped to 9999 and converted; when undefined they are dropped (ovf only).
module binary_to_bcd_stage
  import kpn_display_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAG_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              bcd_valid,
  output logic              busy,
  output logic              ovf
);

  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = $clog2(MAG_W);
  localparam logic [DATA_W-1:0] MAX_DEC_W = DATA_W'(MAX_DEC);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SR_W-1:0]    shiftReg_q;
  logic [SR_W-1:0]    shiftReg_d;
  logic [BCD_W-1:0]   bcdOut_q;
  logic               bcdValid_q;
  logic [BCD_W-1:0]   digitsAdj;
  logic [MAG_W-1:0]   magLoad;
  logic               overRange;

  // Correct every digit of the BCD field before it is shifted.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : gDigit
    bcd_add3 u_add3 (
      .digit_i (shiftReg_q[MAG_W + DIGIT_W*g +: DIGIT_W]),
      .digit_o (digitsAdj[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign shiftReg_d = {digitsAdj, shiftReg_q[MAG_W-1:0]} << 1;

  assign overRange = (fifo_data > MAX_DEC_W);

`ifdef BCD_SATURATE_EN
  assign magLoad = overRange ? MAG_W'(MAX_DEC) : fifo_data[MAG_W-1:0];
`else
  assign magLoad = fifo_data[MAG_W-1:0];
`endif

  // The read strobe, busy and ovf are decoded from the state register so they
  // line up with the FIFO handshake cycle (pop in IDLE, data in CAPTURE).
  assign fifo_rd   = (state_q == IDLE) && !fifo_empty;
  assign busy      = (state_q != IDLE);
  assign ovf       = (state_q == CAPTURE) && overRange;
  assign bcd_out   = bcdOut_q;
  assign bcd_valid = bcdValid_q;

  // Conversion FSM: the result is loaded on the last shift so that bcd_out and
  // bcd_valid are already presented during the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shiftReg_q <= '0;
      bcdOut_q   <= '0;
      bcdValid_q <= 1'b0;
    end else begin
      bcdValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          shiftReg_q <= {{BCD_W{1'b0}}, magLoad};
          cnt_q      <= '0;
`ifdef BCD_SATURATE_EN
          state_q    <= SHIFT;
`else
          state_q    <= overRange ? IDLE : SHIFT;
`endif
        end
        SHIFT: begin
          shiftReg_q <= shiftReg_d;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAG_W - 1)) begin
            bcdOut_q   <= shiftReg_d[SR_W-1 -: BCD_W];
            bcdValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_stage.sv
// Testbench for binary_to_bcd_stage: a FIFO model feeds directed words, the
// expected result of each word is queued at push time and a negedge monitor
// checks handshake timing, ovf, bcd_valid, bcd_out and busy cycle by cycle.
module tb_binary_to_bcd_stage;

  typedef struct packed {
    logic        valid;
    logic        ovf;
    logic [15:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        ovf;

  exp_t        expQ[$];
  logic [15:0] fifoQ[$];
  int          validCycQ[$];
  int          rdCycQ[$];

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic        inflight   = 1'b0;
  int          rdCyc      = 0;
  exp_t        cur;
  logic [15:0] modelBcd   = 16'h0000;
  logic        prevRd     = 1'b0;

  binary_to_bcd_stage #(
    .DATA_W (16),
    .MAG_W  (14)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Queue one FIFO word together with the response it should produce.
  task automatic applyStimulus(input logic [15:0] word, input logic expValid,
                               input logic expOvf, input logic [15:0] expBcd);
    exp_t e;
    e.valid = expValid;
    e.ovf   = expOvf;
    e.bcd   = expBcd;
    expQ.push_back(e);
    fifoQ.push_back(word);
    fifo_empty = (fifoQ.size() == 0);
  endtask

  // Wait (bounded) until every queued word has been consumed and resolved.
  task automatic waitIdle(input string name);
    int k = 0;
    while ((fifoQ.size() != 0 || expQ.size() != 0 || inflight) && k < 300) begin
      @(posedge clk);
      k++;
    end
    checkOutput({name, "_timeout"}, 32'(k >= 300), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // FIFO model: a strobe seen mid-cycle pops the head word just after the edge.
  always begin
    @(negedge clk);
    if (fifo_rd && !reset) begin
      @(posedge clk);
      #1;
      if (fifoQ.size() != 0) fifo_data = fifoQ.pop_front();
      fifo_empty = (fifoQ.size() == 0);
    end
  end

  // Monitor: pairs each read strobe with its expected entry and checks the
  // outputs at the fixed latencies; every other cycle outputs must be quiet.
  always @(negedge clk) begin
    logic expBusy;
    cyc++;
    if (reset) begin
      inflight = 1'b0;
      modelBcd = 16'h0000;
    end else begin
      if (fifo_rd) begin
        checkOutput("rd_back_to_back", 32'(prevRd), 32'd0);
        checkOutput("rd_only_when_idle", 32'(inflight), 32'd0);
        rdCycQ.push_back(cyc);
        if (expQ.size() == 0) begin
          checkOutput("rd_unexpected", 32'd1, 32'(expQ.size()));
        end else begin
          cur      = expQ.pop_front();
          inflight = 1'b1;
          rdCyc    = cyc;
        end
      end
      expBusy = inflight && (cyc != rdCyc);
      checkOutput("busy", 32'(busy), 32'(expBusy));
      if (inflight && cyc == rdCyc + 1) begin
        checkOutput("ovf_pulse", 32'(ovf), 32'(cur.ovf));
        if (!cur.valid) inflight = 1'b0;
      end else begin
        checkOutput("ovf_quiet", 32'(ovf), 32'd0);
      end
      if (inflight && cyc == rdCyc + 16) begin
        checkOutput("bcd_valid_pulse", 32'(bcd_valid), 32'd1);
        modelBcd = cur.bcd;
        checkOutput("bcd_out_result", 32'(bcd_out), 32'(modelBcd));
        inflight = 1'b0;
      end else begin
        checkOutput("bcd_valid_quiet", 32'(bcd_valid), 32'd0);
        checkOutput("bcd_out_hold", 32'(bcd_out), 32'(modelBcd));
      end
      if (bcd_valid) validCycQ.push_back(cyc);
    end
    prevRd = fifo_rd && !reset;
  end

  // Absolute time limit so the run always reaches an end.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int k;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_bcd_out", 32'(bcd_out), 32'h0000);
    checkOutput("reset_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("reset_bcd_valid", 32'(bcd_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single word 1234");
    applyStimulus(16'd1234, 1'b1, 1'b0, 16'h1234);
    waitIdle("t1");

    $display("[TB] back-to-back 0 and 9999");
    n = validCycQ.size();
    applyStimulus(16'd0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(16'd9999, 1'b1, 1'b0, 16'h9999);
    waitIdle("t2");
    checkOutput("t2_valid_count", 32'(validCycQ.size() - n), 32'd2);
    if (validCycQ.size() >= n + 2)
      checkOutput("t2_valid_gap", 32'(validCycQ[n+1] - validCycQ[n]), 32'd17);

    $display("[TB] out-of-range words 10000 and 65535");
    applyStimulus(16'd42, 1'b1, 1'b0, 16'h0042);
    waitIdle("t3a");
`ifdef BCD_SATURATE_EN
    applyStimulus(16'd10000, 1'b1, 1'b1, 16'h9999);
    applyStimulus(16'd65535, 1'b1, 1'b1, 16'h9999);
    waitIdle("t3b");
    checkOutput("t3_saturated", 32'(bcd_out), 32'h9999);
`else
    applyStimulus(16'd10000, 1'b0, 1'b1, 16'h0000);
    applyStimulus(16'd65535, 1'b0, 1'b1, 16'h0000);
    waitIdle("t3b");
    checkOutput("t3_dropped_keeps", 32'(bcd_out), 32'h0042);
`endif

    $display("[TB] three queued words 7, 80, 605");
    n = rdCycQ.size();
    applyStimulus(16'd7, 1'b1, 1'b0, 16'h0007);
    applyStimulus(16'd80, 1'b1, 1'b0, 16'h0080);
    applyStimulus(16'd605, 1'b1, 1'b0, 16'h0605);
    waitIdle("t4");
    checkOutput("t4_rd_count", 32'(rdCycQ.size() - n), 32'd3);
    if (rdCycQ.size() >= n + 3) begin
      checkOutput("t4_rd_gap1", 32'(rdCycQ[n+1] - rdCycQ[n]), 32'd17);
      checkOutput("t4_rd_gap2", 32'(rdCycQ[n+2] - rdCycQ[n+1]), 32'd17);
    end

    $display("[TB] reset during conversion of 4321");
    n = rdCycQ.size();
    applyStimulus(16'd4321, 1'b1, 1'b0, 16'h4321);
    k = 0;
    while (rdCycQ.size() == n && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_rd_seen", 32'(rdCycQ.size() - n), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_reset_bcd_out", 32'(bcd_out), 32'h0000);
    checkOutput("t5_reset_busy", 32'(busy), 32'd0);
    checkOutput("t5_reset_valid", 32'(bcd_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_after_bcd_out", 32'(bcd_out), 32'h0000);
    checkOutput("t5_after_busy", 32'(busy), 32'd0);
    checkOutput("t5_fifo_untouched", 32'(fifoQ.size()), 32'd0);
    n = rdCycQ.size();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t5_no_new_rd", 32'(rdCycQ.size() - n), 32'd0);

    $display("[TB] FIFO empty for 50 cycles");
    n = rdCycQ.size();
    repeat (50) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_no_rd", 32'(rdCycQ.size() - n), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_bcd_stable", 32'(bcd_out), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
